// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode and funct codes, the ALU operation set,
// and the default BIOS base address used as the post-reset PC.
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 value selecting SUB / SRA; only its bit 5 (instr[30]) is decoded.
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // Immediate forms have no SUBI, so alt only selects SUB for register ops.
  function automatic alu_op_e alu_op_for(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       is_reg);
    alu_op_e op;
    case (funct3)
      F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_cpu_bios_rom.sv
// 4096-word BIOS ROM with a combinational read; contents are loaded from
// outside the design (image preload), so there is no write port.
module bios_rom (
  input  logic [11:0] addr,
  output logic [31:0] data
);

  reg [31:0] mem [0:4095];

  assign data = mem[addr];

endmodule

// File: rtl/rv32i_cpu_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hard-wired to zero, and a synchronous clear of every entry on reset.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  reg [31:0] mem [0:31];

  // Reset wins over a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core: fetch from BIOS ROM, decode, ALU and branch unit
// inline, retire one instruction per clock into the register file.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter int          CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out
);

  // The UART is not built yet: clock frequency and RX are held for later use.
  localparam int unused_clock_freq = CPU_CLOCK_FREQ;
  logic unused_serial_in;
  assign unused_serial_in = serial_in;
  assign serial_out       = 1'b1;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        alt;

  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  alu_op_e     alu_op;
  logic        br_taken;
  logic        rf_we;
  logic [31:0] wb_data;

  bios_rom bios_mem (
    .addr (pc[13:2]),
    .data (instr)
  );

  reg_file rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .we  (rf_we),
    .wd  (wb_data),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alt    = instr[30];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Anything not decoded here (loads, stores, FENCE, SYSTEM, junk) is a NOP.
  always_comb begin
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    alu_op  = ALU_ADD;
    rf_we   = 1'b0;
    wb_data = alu_y;
    pc_next = pc_plus4;
    case (opcode)
      OPC_OP: begin
        alu_op = alu_op_for(funct3, alt, 1'b1);
        rf_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_op_for(funct3, alt, 1'b0);
        rf_we  = 1'b1;
      end
      OPC_LUI: begin
        rf_we   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
        rf_we = 1'b1;
      end
      OPC_JAL: begin
        rf_we   = 1'b1;
        wb_data = pc_plus4;
        pc_next = pc + imm_j;
      end
      OPC_JALR: begin
        alu_b   = imm_i;
        rf_we   = 1'b1;
        wb_data = pc_plus4;
        pc_next = {alu_y[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Bench for rv32i_cpu: directed programs with hand-computed results plus a
// randomly filled ROM, all run in lockstep with an instruction-level model.
module tb_rv32i_cpu;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [6:0]  OP   = 7'h33;
  localparam logic [6:0]  OPI  = 7'h13;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b1;
  logic serial_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rom [0:4095];
  logic [31:0] m_x [0:31];
  logic [31:0] m_pc;
  logic [31:0] exp_q [$];

  rv32i_cpu #(.CPU_CLOCK_FREQ(50_000_000), .RESET_PC(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Instruction-set reference: integer semantics written straight from the ISA rules.
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = 32'(int'(a) >>> sh);
        else     r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_pc = BASE;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, res, nxt, ii, ib, ij;
    logic wr, taken;
    ins = rom[m_pc[13:2]];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = 32'($signed(ins[31:20]));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    res = 32'd0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h0}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h0}; end
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + ii) & ~32'd1; end
      7'h63: begin
        case (ins[14:12])
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = (int'(a) < int'(b));
          3'd5: taken = (int'(a) >= int'(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) nxt = m_pc + ib;
      end
      7'h13: begin wr = 1'b1; res = alu_ref(ins[14:12], (ins[14:12] == 3'd5) && ins[30], a, ii); end
      7'h33: begin wr = 1'b1; res = alu_ref(ins[14:12], ins[30], a, b); end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  // One clock: advance the model alongside the DUT, compare PC after the edge.
  task automatic cycle();
    if (!rst) model_reset();
    else      model_step();
    serial_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    check("pc", dut.pc, m_pc);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.rf.mem[i], m_x[i]);
  endtask

  task automatic load_rom();
    for (int i = 0; i < 4096; i++) dut.bios_mem.mem[i] = rom[i];
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = NOP;
  endtask

  task automatic start_program();
    rst = 1'b0;
    load_rom();
    cycle();
    rst = 1'b1;
  endtask

  task automatic wait_x20(input logic [31:0] val, input int budget);
    int n;
    n = 0;
    while (dut.rf.mem[20] !== val && n < budget) begin
      cycle();
      n++;
    end
    check("x20_reached", dut.rf.mem[20], val);
  endtask

  // Expected register values for a directed program, queued as {index, value} pairs.
  task automatic check_expected(input string tag);
    logic [31:0] idx, val;
    while (exp_q.size() >= 2) begin
      idx = exp_q.pop_front();
      val = exp_q.pop_front();
      check($sformatf("%s_x%0d", tag, idx), dut.rf.mem[idx[4:0]], val);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [2:0] bf3 [6];
    logic [6:0] nops [5];
    rd = 5'($urandom_range(0, 15));
    r1 = 5'($urandom_range(0, 15));
    r2 = 5'($urandom_range(0, 15));
    f3 = 3'($urandom_range(0, 7));
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    nops = '{7'h03, 7'h23, 7'h0f, 7'h73, 7'h00};
    case ($urandom_range(0, 9))
      0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         r2, r1, f3, rd, OP);
      2, 3: begin
        if (f3 == 3'd1)      return enc_i({7'h00, 5'($urandom)}, r1, f3, rd, OPI);
        else if (f3 == 3'd5) return enc_i({($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)}, r1, f3, rd, OPI);
        else                 return enc_i(12'($urandom), r1, f3, rd, OPI);
      end
      4:  return enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      5, 6: return enc_b(13'(($urandom_range(0, 32) - 16) * 4), r2, r1, bf3[$urandom_range(0, 5)]);
      7:  return enc_j(21'(($urandom_range(0, 32) - 16) * 4), rd);
      8:  return enc_i(12'($urandom), r1, 3'd0, rd, 7'h67);
      default: return {25'($urandom), nops[$urandom_range(0, 4)]};
    endcase
  endfunction

  initial begin
    clear_rom();
    load_rom();
    model_reset();

    // Reset held for 10 cycles
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("serial_out_rst", {31'b0, serial_out}, 32'd1);
    end
    check("pc_reset", dut.pc, 32'h4000_0000);
    for (int i = 0; i < 32; i++) check($sformatf("rst_x%0d", i), dut.rf.mem[i], 32'd0);

    // ADD
    clear_rom();
    rom[0] = enc_i(12'd100, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = enc_i(12'd200, 5'd0, 3'd0, 5'd2, OPI);
    rom[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1, OP);
    rom[3] = enc_i(12'd1, 5'd0, 3'd0, 5'd20, OPI);
    start_program();
    wait_x20(32'd1, 100);
    exp_q = '{32'd1, 32'd300, 32'd2, 32'd200};
    check_expected("add");
    check_regs("add_model");

    // BEQ taken skips one instruction
    clear_rom();
    rom[0] = enc_i(12'd500, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = enc_i(12'd100, 5'd0, 3'd0, 5'd2, OPI);
    rom[2] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
    rom[3] = enc_i(12'd7, 5'd0, 3'd0, 5'd2, OPI);
    rom[4] = enc_i(12'd2, 5'd0, 3'd0, 5'd20, OPI);
    start_program();
    wait_x20(32'd2, 100);
    exp_q = '{32'd1, 32'd500, 32'd2, 32'd100};
    check_expected("beq");

    // Not-taken BNE/BLT, JAL link and JALR return
    clear_rom();
    rom[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = enc_b(13'd8, 5'd1, 5'd1, 3'd1);
    rom[2] = enc_b(13'd8, 5'd0, 5'd1, 3'd4);
    rom[3] = enc_j(21'd8, 5'd5);
    rom[4] = enc_i(12'd3, 5'd0, 3'd0, 5'd20, OPI);
    rom[5] = enc_i(12'd0, 5'd5, 3'd0, 5'd0, 7'h67);
    start_program();
    wait_x20(32'd3, 100);
    exp_q = '{32'd5, 32'h4000_0010, 32'd1, 32'd1};
    check_expected("jal");
    check("jalr_return_pc", dut.pc, 32'h4000_0014);

    // x0 and arithmetic edge cases
    clear_rom();
    rom[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI);
    rom[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    rom[2] = enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd3, OP);
    rom[3] = enc_u(20'h80000, 5'd4, 7'h37);
    rom[4] = enc_i({7'h20, 5'd31}, 5'd4, 3'd5, 5'd6, OPI);
    rom[5] = enc_i(12'd31, 5'd0, 3'd0, 5'd7, OPI);
    rom[6] = enc_r(7'h20, 5'd7, 5'd4, 3'd5, 5'd8, OP);
    rom[7] = enc_r(7'h00, 5'd3, 5'd1, 3'd3, 5'd9, OP);
    rom[8] = enc_i(12'd4, 5'd0, 3'd0, 5'd20, OPI);
    start_program();
    wait_x20(32'd4, 100);
    exp_q = '{32'd0, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFF,
              32'd8, 32'hFFFF_FFFF, 32'd9, 32'd1};
    check_expected("edge");
    check_regs("edge_model");

    // Mid-run reset after 5 instructions, then identical re-execution
    start_program();
    for (int i = 0; i < 5; i++) cycle();
    rst = 1'b0;
    cycle();
    check("pc_midreset", dut.pc, 32'h4000_0000);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_x%0d", i), dut.rf.mem[i], 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    exp_q = '{32'd3, 32'hFFFF_FFFF, 32'd9, 32'd1, 32'd20, 32'd4};
    check_expected("rerun");
    check_regs("rerun_model");

    // Random ROM image in lockstep with the model
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4096; i++) rom[i] = rand_instr();
      start_program();
      for (int c = 0; c < 1500; c++) begin
        cycle();
        if (c % 250 == 249) check_regs($sformatf("rand%0d_c%0d", t, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
